cp_bus_waitgen: RTL and testbench



---
 rtl/cp_bus_waitgen.sv | 117 +++++++++++
 tb/tb_cp_bus_waitgen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_bus_waitgen.sv
// uPD7801 CP1/CP2 strobe generator with per-region chip selects and wait-state insertion.
// WAITB is low for N CP1 periods per new access; EXT_WAITB is ANDed in combinationally.
module cp_bus_waitgen #(
    parameter int DIV = 1,
    parameter int RB  = 1,
    parameter int WW  = 4,
    parameter logic [(1<<RB)*WW-1:0] WAITS = {WW'(1), WW'(0)}
) (
    input  logic                 CLK,
    input  logic                 RES,
    input  logic [15:0]          A,
    input  logic                 A_OE,
    input  logic                 RDB,
    input  logic                 WRB,
    input  logic                 EXT_WAITB,
    output logic                 CP1_POSEDGE,
    output logic                 CP1_NEGEDGE,
    output logic                 CP2_POSEDGE,
    output logic                 CP2_NEGEDGE,
    output logic [(1<<RB)-1:0]   CS_N,
    output logic                 WAITB
);

    localparam int NREG = 1 << RB;
    localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    quad_q, quad_d;
    logic [3:0]    strb_q, strb_d;
    logic          wrap;

    logic [15:0]   addr_q, addr_d;
    logic          act_q, act_d;
    logic          wait_q, wait_d;
    logic [WW-1:0] cnt_q, cnt_d;

    logic [RB-1:0] region;
    logic [WW-1:0] n_sel;
    logic          strobe;
    logic          new_acc;

    // Quadrant starts at 3 so the first wrap enters quadrant 0 (CP1 rise).
    always_comb begin
        wrap   = (div_q == DW'(DIV - 1));
        div_d  = wrap ? '0 : div_q + 1'b1;
        quad_d = wrap ? quad_q + 2'd1 : quad_q;
        strb_d = 4'b0000;
        if (wrap) begin
            strb_d[quad_d] = 1'b1;
        end
    end

    always_comb begin
        region = A[15 -: RB];
        n_sel  = WAITS[int'(region)*WW +: WW];
        for (int i = 0; i < NREG; i++) begin
            CS_N[i] = ~(A_OE & (region == RB'(i)));
        end
    end

    always_comb begin
        strobe  = A_OE & (~RDB | ~WRB);
        new_acc = strobe & (~act_q | (A != addr_q));
        addr_d  = addr_q;
        act_d   = act_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        if (strb_q[0]) begin
            if (!strobe) begin
                act_d  = 1'b0;
                cnt_d  = '0;
                wait_d = 1'b1;
            end else if (new_acc) begin
                addr_d = A;
                act_d  = 1'b1;
                if (n_sel == '0) begin
                    wait_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    wait_d = 1'b0;
                    cnt_d  = n_sel - WW'(1);
                end
            end else if (!wait_q && (cnt_q == '0)) begin
                wait_d = 1'b1;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - WW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            div_q  <= '0;
            quad_q <= 2'd3;
            strb_q <= 4'b0000;
            addr_q <= '0;
            act_q  <= 1'b0;
            wait_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            div_q  <= div_d;
            quad_q <= quad_d;
            strb_q <= strb_d;
            addr_q <= addr_d;
            act_q  <= act_d;
            wait_q <= wait_d;
            cnt_q  <= cnt_d;
        end
    end

    assign CP1_POSEDGE = strb_q[0];
    assign CP1_NEGEDGE = strb_q[1];
    assign CP2_POSEDGE = strb_q[2];
    assign CP2_NEGEDGE = strb_q[3];
    assign WAITB       = wait_q & EXT_WAITB;

endmodule

// File: tb/tb_cp_bus_waitgen.sv
// Directed bench for cp_bus_waitgen: DIV=1 default, DIV=3, and a 3-wait region-1 variant.
module tb_cp_bus_waitgen;

    logic        clk;
    logic        res;
    logic [15:0] a;
    logic        a_oe;
    logic        rdb;
    logic        wrb;
    logic        ext;

    logic [3:0]  strb_a, strb_b, strb_c;
    logic [1:0]  csn_a, csn_b, csn_c;
    logic        wb_a, wb_b, wb_c;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cp_bus_waitgen u_a (
        .CLK(clk), .RES(res), .A(a), .A_OE(a_oe), .RDB(rdb), .WRB(wrb), .EXT_WAITB(ext),
        .CP1_POSEDGE(strb_a[0]), .CP1_NEGEDGE(strb_a[1]),
        .CP2_POSEDGE(strb_a[2]), .CP2_NEGEDGE(strb_a[3]),
        .CS_N(csn_a), .WAITB(wb_a)
    );

    cp_bus_waitgen #(.DIV(3)) u_b (
        .CLK(clk), .RES(res), .A(a), .A_OE(a_oe), .RDB(rdb), .WRB(wrb), .EXT_WAITB(ext),
        .CP1_POSEDGE(strb_b[0]), .CP1_NEGEDGE(strb_b[1]),
        .CP2_POSEDGE(strb_b[2]), .CP2_NEGEDGE(strb_b[3]),
        .CS_N(csn_b), .WAITB(wb_b)
    );

    cp_bus_waitgen #(.WAITS(8'h30)) u_c (
        .CLK(clk), .RES(res), .A(a), .A_OE(a_oe), .RDB(rdb), .WRB(wrb), .EXT_WAITB(ext),
        .CP1_POSEDGE(strb_c[0]), .CP1_NEGEDGE(strb_c[1]),
        .CP2_POSEDGE(strb_c[2]), .CP2_NEGEDGE(strb_c[3]),
        .CS_N(csn_c), .WAITB(wb_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic bus_idle();
        a    = 16'h0000;
        a_oe = 1'b0;
        rdb  = 1'b1;
        wrb  = 1'b1;
        ext  = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after RES falls; the next posedge is edge 1.
    task automatic do_reset();
        bus_idle();
        res = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        res = 1'b0;
    endtask

    task automatic test_reset();
        bus_idle();
        res = 1'b1;
        #3;
        total_cnt++;
        if (strb_a !== 4'b0000) $display("FAIL reset_strb_a: got %b expected %b", strb_a, 4'b0000);
        else pass_cnt++;
        total_cnt++;
        if (wb_a !== 1'b1) $display("FAIL reset_waitb: got %b expected %b", wb_a, 1'b1);
        else pass_cnt++;
        total_cnt++;
        if (csn_a !== 2'b11) $display("FAIL reset_csn: got %b expected %b", csn_a, 2'b11);
        else pass_cnt++;
    endtask

    task automatic test_phase();
        logic [3:0] exp_a, exp_b;
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            step();
            exp_a = 4'b0001 << ((e - 1) % 4);
            exp_b = (e % 3 == 0) ? (4'b0001 << (((e / 3) - 1) % 4)) : 4'b0000;
            total_cnt++;
            if (strb_a !== exp_a) $display("FAIL phase_div1 edge%0d: got %b expected %b", e, strb_a, exp_a);
            else pass_cnt++;
            total_cnt++;
            if (strb_b !== exp_b) $display("FAIL phase_div3 edge%0d: got %b expected %b", e, strb_b, exp_b);
            else pass_cnt++;
        end
    endtask

    task automatic test_read_n1();
        logic exp;
        do_reset();
        step();
        a = 16'h8000; a_oe = 1'b1; rdb = 1'b0;
        #1;
        total_cnt++;
        if (csn_a !== 2'b01) $display("FAIL read_n1_csn: got %b expected %b", csn_a, 2'b01);
        else pass_cnt++;
        for (int e = 2; e <= 10; e++) begin
            step();
            exp = (e >= 2 && e <= 5) ? 1'b0 : 1'b1;
            total_cnt++;
            if (wb_a !== exp) $display("FAIL read_n1_waitb edge%0d: got %b expected %b", e, wb_a, exp);
            else pass_cnt++;
        end
        bus_idle();
    endtask

    task automatic test_read_n0();
        do_reset();
        step();
        a = 16'h0100; a_oe = 1'b1; rdb = 1'b0;
        #1;
        total_cnt++;
        if (csn_a !== 2'b10) $display("FAIL read_n0_csn: got %b expected %b", csn_a, 2'b10);
        else pass_cnt++;
        for (int e = 2; e <= 9; e++) begin
            step();
            total_cnt++;
            if (wb_a !== 1'b1) $display("FAIL read_n0_waitb edge%0d: got %b expected %b", e, wb_a, 1'b1);
            else pass_cnt++;
        end
        bus_idle();
    endtask

    task automatic test_write_n3();
        logic exp;
        do_reset();
        step();
        a = 16'h9000; a_oe = 1'b1; wrb = 1'b0;
        for (int e = 2; e <= 18; e++) begin
            step();
            exp = (e >= 2 && e <= 13) ? 1'b0 : 1'b1;
            total_cnt++;
            if (wb_c !== exp) $display("FAIL write_n3_waitb edge%0d: got %b expected %b", e, wb_c, exp);
            else pass_cnt++;
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic exp;
        do_reset();
        step();
        a = 16'h8000; a_oe = 1'b1; rdb = 1'b0;
        for (int e = 2; e <= 16; e++) begin
            step();
            exp = ((e >= 2 && e <= 5) || (e >= 10 && e <= 13)) ? 1'b0 : 1'b1;
            total_cnt++;
            if (wb_a !== exp) $display("FAIL b2b_waitb edge%0d: got %b expected %b", e, wb_a, exp);
            else pass_cnt++;
            if (e == 9) a = 16'h8001;
        end
        bus_idle();
    endtask

    task automatic test_abort();
        logic exp;
        do_reset();
        step();
        a = 16'h9000; a_oe = 1'b1; wrb = 1'b0;
        for (int e = 2; e <= 23; e++) begin
            step();
            exp = ((e >= 2 && e <= 5) || (e >= 10 && e <= 21)) ? 1'b0 : 1'b1;
            total_cnt++;
            if (wb_c !== exp) $display("FAIL abort_waitb edge%0d: got %b expected %b", e, wb_c, exp);
            else pass_cnt++;
            if (e == 5) wrb = 1'b1;
            if (e == 9) wrb = 1'b0;
        end
        bus_idle();
    endtask

    task automatic test_ext_wait();
        logic exp;
        do_reset();
        step();
        a = 16'h0100; a_oe = 1'b1; rdb = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            ext = e[0];
            #1;
            total_cnt++;
            if (wb_a !== ext) $display("FAIL ext_follow step%0d: got %b expected %b", e, wb_a, ext);
            else pass_cnt++;
            step();
        end
        do_reset();
        step();
        a = 16'h8000; a_oe = 1'b1; rdb = 1'b0; ext = 1'b0;
        for (int e = 2; e <= 7; e++) begin
            step();
            if (e == 5) ext = 1'b1;
            #1;
            exp = (e <= 5) ? 1'b0 : 1'b1;
            total_cnt++;
            if (wb_a !== exp) $display("FAIL ext_count edge%0d: got %b expected %b", e, wb_a, exp);
            else pass_cnt++;
        end
        bus_idle();
    endtask

    task automatic test_reset_midwait();
        do_reset();
        step();
        a = 16'h9000; a_oe = 1'b1; wrb = 1'b0;
        for (int e = 2; e <= 4; e++) step();
        total_cnt++;
        if (wb_c !== 1'b0) $display("FAIL midwait_pre_waitb: got %b expected %b", wb_c, 1'b0);
        else pass_cnt++;
        #2;
        res = 1'b1;
        #1;
        total_cnt++;
        if (wb_c !== 1'b1) $display("FAIL midwait_waitb: got %b expected %b", wb_c, 1'b1);
        else pass_cnt++;
        total_cnt++;
        if ({strb_a, strb_b, strb_c} !== 12'h000)
            $display("FAIL midwait_strb: got %h expected %h", {strb_a, strb_b, strb_c}, 12'h000);
        else pass_cnt++;
        bus_idle();
        @(posedge clk);
        #1;
        res = 1'b0;
        step();
        total_cnt++;
        if (strb_a !== 4'b0001) $display("FAIL restart_strb: got %b expected %b", strb_a, 4'b0001);
        else pass_cnt++;
        total_cnt++;
        if (wb_c !== 1'b1) $display("FAIL restart_waitb: got %b expected %b", wb_c, 1'b1);
        else pass_cnt++;
    endtask

    initial begin
        res = 1'b1;
        bus_idle();
        test_reset();
        test_phase();
        test_read_n1();
        test_read_n0();
        test_write_n3();
        test_back_to_back();
        test_abort();
        test_ext_wait();
        test_reset_midwait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
